// File: rtl/gcd_feeder_if.sv
// Operand/result handshake bundle between the GCD feeder and its environment.
// Latency: none, wiring only.
// Backpressure: carries in_valid/in_ready and res_valid/res_ready pairs; master is the feeder, slave is the environment.
interface gcd_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic       core_load;
    logic [7:0] core_x;
    logic [7:0] core_y;
    logic [7:0] core_gcd;
    logic       core_finish;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_gcd;
    logic       res_err;
    logic       busy;
    logic [4:0] fifo_count;

    // Feeder side
    modport master (
        input  in_valid, in_x, in_y, core_gcd, core_finish, res_ready,
        output in_ready, core_load, core_x, core_y, res_valid, res_gcd, res_err,
               busy, fifo_count
    );

    // Environment side: producer, GCD datapath and result consumer
    modport slave (
        output in_valid, in_x, in_y, core_gcd, core_finish, res_ready,
        input  in_ready, core_load, core_x, core_y, res_valid, res_gcd, res_err,
               busy, fifo_count
    );
endinterface

// File: rtl/gcd_feeder.sv
// Queues operand pairs and sequences them through an external GCD datapath with a watchdog.
// Latency: 3 cycles pop-to-res_valid minimum (IDLE pop, LOAD, WAIT with finish); zero-operand pairs skip the datapath.
// Backpressure: in_ready drops when the queue is full; a result is held in RESULT until res_ready.
// Optional feature: define GCD_ZERO_BYPASS_EN to answer zero-operand pairs with the nonzero operand instead of an error.
module gcd_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic          clk,
    input  logic          reset,
    gcd_feeder_if.master  fb
);
    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESULT} state_t;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic          push, pop;
    logic [7:0]    head_x, head_y;

    state_t        state_q;
    logic [7:0]    core_x_q, core_y_q;
    logic          core_load_q;
    logic [9:0]    cnt_q;
    logic          res_valid_q;
    logic [7:0]    res_gcd_q;
    logic          res_err_q;
    logic          busy_q;

    // Ready depends on the registered count only, so a pop in the same cycle never frees a slot early.
    assign fb.in_ready = (count_q < 5'(FIFO_DEPTH));
    assign push        = fb.in_valid && fb.in_ready;
    assign pop         = (state_q == IDLE) && (count_q != 5'd0);
    assign head_x      = mem_q[rd_ptr_q][15:8];
    assign head_y      = mem_q[rd_ptr_q][7:0];

    // Occupancy next-state: a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fb.in_x, fb.in_y};
        end
    end

    // Queue pointers and count; power-of-two depth makes the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Sequencer: pop, pulse load, wait for finish or watchdog, hold result until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            core_x_q    <= 8'd0;
            core_y_q    <= 8'd0;
            core_load_q <= 1'b0;
            cnt_q       <= 10'd0;
            res_valid_q <= 1'b0;
            res_gcd_q   <= 8'd0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        core_x_q <= head_x;
                        core_y_q <= head_y;
                        busy_q   <= 1'b1;
                        if (head_x == 8'd0 || head_y == 8'd0) begin
`ifdef GCD_ZERO_BYPASS_EN
                            res_gcd_q <= head_x | head_y;
                            res_err_q <= 1'b0;
`else
                            res_gcd_q <= 8'd0;
                            res_err_q <= 1'b1;
`endif
                            res_valid_q <= 1'b1;
                            state_q     <= RESULT;
                        end else begin
                            core_load_q <= 1'b1;
                            state_q     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // core_finish is deliberately not looked at here: it may be stale.
                    core_load_q <= 1'b0;
                    cnt_q       <= 10'd0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 10'd1;
                    if (fb.core_finish) begin
                        res_gcd_q   <= fb.core_gcd;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else if (cnt_q == TO_LAST) begin
                        res_gcd_q   <= 8'd0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (fb.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset also drives load so the datapath is held cleared while reset is high.
    assign fb.core_load  = core_load_q | reset;
    assign fb.core_x     = core_x_q;
    assign fb.core_y     = core_y_q;
    assign fb.res_valid  = res_valid_q;
    assign fb.res_gcd    = res_gcd_q;
    assign fb.res_err    = res_err_q;
    assign fb.busy       = busy_q;
    assign fb.fifo_count = count_q;
endmodule

// File: tb/tb_gcd_feeder.sv
// Bench for gcd_feeder: vector table, hand-written corner sequences, randomized scoreboard run.
// Latency: the GCD datapath is modelled with a configurable finish delay.
// Backpressure: res_ready and in_valid are driven both fixed and randomly.
module tb_gcd_feeder;
    localparam int TO = 1023;

    logic clk;
    logic reset;
    gcd_feeder_if bus ();

    gcd_feeder #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .fb   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Datapath model controls
    logic       model_en = 1'b1;
    int         lat = 4;
    logic       model_finish = 1'b0;
    logic [7:0] model_gcd = 8'd0;
    logic       man_finish = 1'b0;
    logic [7:0] man_gcd = 8'd0;

    assign bus.core_finish = model_en ? model_finish : man_finish;
    assign bus.core_gcd    = model_en ? model_gcd    : man_gcd;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] g;
        logic       e;
    } vec_t;

    typedef struct {
        logic [7:0] g;
        logic       e;
    } res_t;

    res_t exp_q[$];

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int p = a;
        int q = b;
        while (q != 0) begin
            int t = p % q;
            p = q;
            q = t;
        end
        return 8'(p);
    endfunction

    function automatic res_t ref_result(input logic [7:0] x, input logic [7:0] y);
        res_t r;
        if (x == 8'd0 || y == 8'd0) begin
`ifdef GCD_ZERO_BYPASS_EN
            r.g = (x == 8'd0) ? y : x;
            r.e = 1'b0;
`else
            r.g = 8'd0;
            r.e = 1'b1;
`endif
        end else begin
            r.g = ref_gcd(x, y);
            r.e = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Behavioural GCD datapath: answers gcd(core_x, core_y) a number of cycles after load.
    initial begin
        int cd = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_load) begin
                cd           = (lat == 0) ? int'($urandom_range(1, 12)) : lat;
                model_finish = 1'b0;
                model_gcd    = ref_gcd(bus.core_x, bus.core_y);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) model_finish = 1'b1;
            end
        end
    end

    task automatic push_pair(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push_timeout", 1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits (bounded) for res_valid at a negedge, counting core_load cycles seen meanwhile.
    task automatic wait_result(input string name, output int loads);
        int n = 0;
        loads = 0;
        while (!bus.res_valid && n < 2000) begin
            if (bus.core_load) loads++;
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) chk({name, "_res_timeout"}, 0, 1);
    endtask

    task automatic ack(input string name);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({name, "_valid_drop"}, int'(bus.res_valid), 0);
    endtask

    initial begin
        vec_t tbl[9];
        int   loads;
        logic [7:0] bx[5];
        logic [7:0] by[5];
        int   acc;
        int   maxc;
        int   n;
        int   seen_v;
        int   seen_l;
        int   leaked;
        res_t r;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = 8'd0;
        bus.in_y      = 8'd0;
        bus.res_ready = 1'b0;

`ifdef GCD_ZERO_BYPASS_EN
        tbl[0] = '{8'd0,   8'd12,  8'd12,  1'b0};
        tbl[1] = '{8'd12,  8'd0,   8'd12,  1'b0};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
`else
        tbl[0] = '{8'd0,   8'd12,  8'd0,   1'b1};
        tbl[1] = '{8'd12,  8'd0,   8'd0,   1'b1};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   1'b1};
`endif
        tbl[3] = '{8'd48,  8'd18,  8'd6,   1'b0};
        tbl[4] = '{8'd17,  8'd13,  8'd1,   1'b0};
        tbl[5] = '{8'd100, 8'd75,  8'd25,  1'b0};
        tbl[6] = '{8'd255, 8'd255, 8'd255, 1'b0};
        tbl[7] = '{8'd128, 8'd96,  8'd32,  1'b0};
        tbl[8] = '{8'd1,   8'd200, 8'd1,   1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fifo_count", int'(bus.fifo_count), 0);
        chk("rst_busy",       int'(bus.busy), 0);
        chk("rst_res_valid",  int'(bus.res_valid), 0);
        chk("rst_core_load",  int'(bus.core_load), 1);
        chk("rst_in_ready",   int'(bus.in_ready), 1);
        chk("rst_res_gcd",    int'(bus.res_gcd), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_core_load", int'(bus.core_load), 0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            lat = 1 + i;
            push_pair(tbl[i].x, tbl[i].y);
            wait_result($sformatf("vec%0d", i), loads);
            chk($sformatf("vec%0d_gcd", i), int'(bus.res_gcd), int'(tbl[i].g));
            chk($sformatf("vec%0d_err", i), int'(bus.res_err), int'(tbl[i].e));
            chk($sformatf("vec%0d_loads", i), loads,
                (tbl[i].x == 8'd0 || tbl[i].y == 8'd0) ? 0 : 1);
            ack($sformatf("vec%0d", i));
        end

        // (48,18) with a 10-cycle datapath; result must hold while not accepted
        lat = 10;
        push_pair(8'd48, 8'd18);
        wait_result("hold", loads);
        chk("hold_gcd", int'(bus.res_gcd), 6);
        chk("hold_err", int'(bus.res_err), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_stable%0d", k),
                int'({bus.res_valid, bus.res_err, bus.res_gcd}), int'({1'b1, 1'b0, 8'd6}));
        end
        ack("hold");

        // Back-to-back burst of 5 with consumer stalled
        bx = '{8'd48, 8'd35, 8'd81, 8'd14, 8'd60};
        by = '{8'd18, 8'd21, 8'd27, 8'd49, 8'd48};
        lat  = 3;
        acc  = 0;
        maxc = 0;
        @(negedge clk);
        for (int c = 0; c < 20 && acc < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = bx[acc];
            bus.in_y     = by[acc];
            if (bus.in_ready) acc++;
            @(negedge clk);
            if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        end
        chk("burst_accepted", acc, 5);
        chk("burst_count", int'(bus.fifo_count), 4);
        chk("burst_in_ready", int'(bus.in_ready), 0);
        bus.in_x = 8'd7;
        bus.in_y = 8'd7;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.in_ready) n++;
            @(negedge clk);
            if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        end
        bus.in_valid = 1'b0;
        chk("burst_full_blocked", n, 0);
        chk("burst_max_count", maxc, 4);
        for (int i = 0; i < 5; i++) begin
            r = ref_result(bx[i], by[i]);
            wait_result($sformatf("burst%0d", i), loads);
            chk($sformatf("burst%0d_gcd", i), int'(bus.res_gcd), int'(r.g));
            ack($sformatf("burst%0d", i));
        end

        // Watchdog timeout
        model_en   = 1'b0;
        man_finish = 1'b0;
        push_pair(8'd9, 8'd6);
        n = 0;
        while (!bus.core_load && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_load_seen", int'(bus.core_load), 1);
        n = 0;
        while (!bus.res_valid && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO + 1);
        chk("to_gcd", int'(bus.res_gcd), 0);
        chk("to_err", int'(bus.res_err), 1);
        ack("to");

        // Stale finish during LOAD must be ignored
        man_finish = 1'b1;
        man_gcd    = 8'd77;
        push_pair(8'd8, 8'd4);
        n = 0;
        while (!bus.core_load && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("stale_no_result", int'(bus.res_valid), 0);
        man_finish = 1'b0;
        man_gcd    = 8'd4;
        repeat (2) @(negedge clk);
        chk("stale_waiting", int'(bus.res_valid), 0);
        man_finish = 1'b1;
        wait_result("stale", loads);
        chk("stale_gcd", int'(bus.res_gcd), 4);
        chk("stale_err", int'(bus.res_err), 0);
        man_finish = 1'b0;
        ack("stale");

        // Reset during WAIT with two pairs queued
        push_pair(8'd30, 8'd20);
        push_pair(8'd21, 8'd14);
        push_pair(8'd99, 8'd33);
        repeat (3) @(negedge clk);
        chk("mid_pre_count", int'(bus.fifo_count), 2);
        chk("mid_pre_busy", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", int'(bus.fifo_count), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_valid", int'(bus.res_valid), 0);
        chk("mid_rst_load", int'(bus.core_load), 1);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        model_en = 1'b1;
        seen_v = 0;
        seen_l = 0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.res_valid) seen_v++;
            if (bus.core_load) seen_l++;
        end
        bus.res_ready = 1'b0;
        chk("mid_no_result", seen_v, 0);
        chk("mid_no_load", seen_l, 0);

        // Randomized run against the scoreboard
        lat = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_x      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.in_y      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.res_ready = ($urandom_range(0, 1) != 0);
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_result(bus.in_x, bus.in_y));
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rnd_result", int'({bus.res_err, bus.res_gcd}), int'({r.e, r.g}));
                end
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            if (bus.res_valid) begin
                r = exp_q.pop_front();
                chk("rnd_drain", int'({bus.res_err, bus.res_gcd}), int'({r.e, r.g}));
            end
            @(negedge clk);
            n++;
        end
        bus.res_ready = 1'b0;
        chk("rnd_drained", exp_q.size(), 0);
        leaked = int'(bus.res_valid);
        chk("rnd_idle_valid", leaked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
